// File: rtl/logic_result_stage_if.sv
// Handshake and result bus of the ALU bitwise-logic stage.
// master drives operations and consumes results; slave is the stage itself.
interface logic_result_stage_if #(
    parameter int unsigned w = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [w-1:0] in_0;
    logic [w-1:0] in_1;
    logic         out_valid;
    logic         out_ready;
    logic [w-1:0] result;
    logic         zero;
    logic         neg;
    logic         parity;

    modport master (
        output in_valid, op, in_0, in_1, out_ready,
        input  in_ready, out_valid, result, zero, neg, parity
    );

    modport slave (
        input  in_valid, op, in_0, in_1, out_ready,
        output in_ready, out_valid, result, zero, neg, parity
    );
endinterface

// File: rtl/logic_result_stage.sv
// Registered AND/OR/XOR/NOT stage with zero/neg/parity flags and a
// 2-entry output FIFO; the outputs always present the head entry.
module logic_result_stage #(
    parameter int unsigned w = 64
) (
    input logic                  clk,
    input logic                  rst_n,
    logic_result_stage_if.slave  bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [w-1:0] result;
        logic         zero;
        logic         neg;
        logic         parity;
    } entry_t;

    state_t       state_q, state_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    entry_t       mem_q [2];
    entry_t       head_q, head_d;
    entry_t       new_c;
    logic [w-1:0] res_c;
    logic         push_c;
    logic         pop_c;

    function automatic logic [w-1:0] xor_wordgate(input logic [w-1:0] a,
                                                  input logic [w-1:0] b);
        return a ^ b;
    endfunction

    // Operation and flags, computed at push time and stored with the entry
    always_comb begin
        res_c = '0;
        case (bus.op)
            2'b00:   res_c = bus.in_0 & bus.in_1;
            2'b01:   res_c = bus.in_0 | bus.in_1;
            2'b10:   res_c = xor_wordgate(bus.in_0, bus.in_1);
            default: res_c = ~bus.in_0;
        endcase
        new_c.result = res_c;
        new_c.zero   = ~|res_c;
        new_c.neg    = res_c[w-1];
        new_c.parity = ^res_c;
    end

    assign bus.in_ready  = rst_n && (state_q != FULL);
    assign bus.out_valid = (state_q != EMPTY);
    assign bus.result    = head_q.result;
    assign bus.zero      = head_q.zero;
    assign bus.neg       = head_q.neg;
    assign bus.parity    = head_q.parity;

    assign push_c = bus.in_valid && bus.in_ready;
    assign pop_c  = (state_q != EMPTY) && bus.out_ready;

    // Next state, pointers and the head entry shown in the next cycle
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        head_d   = head_q;

        if (push_c) wr_ptr_d = ~wr_ptr_q;
        if (pop_c)  rd_ptr_d = ~rd_ptr_q;

        case (state_q)
            EMPTY: if (push_c) state_d = ONE;
            ONE: begin
                if (push_c && !pop_c)      state_d = FULL;
                else if (pop_c && !push_c) state_d = EMPTY;
            end
            FULL:    if (pop_c) state_d = ONE;
            default: state_d = EMPTY;
        endcase

        // An empty buffer keeps showing the last popped entry
        if (state_d != EMPTY) begin
            if (push_c && (rd_ptr_d == wr_ptr_q)) head_d = new_c;
            else                                  head_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            head_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
            if (push_c) mem_q[wr_ptr_q] <= new_c;
        end
    end
endmodule

// File: tb/tb_logic_result_stage.sv
// Bench for logic_result_stage: a w=8 and a w=64 instance checked every cycle
// against a queue model, plus directed vectors with literal expectations.
module tb_logic_result_stage;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        iv  [2];
    logic [1:0]  opv [2];
    logic [63:0] av  [2];
    logic [63:0] bv  [2];
    logic        orv [2];

    logic        o_iready [2];
    logic        o_valid  [2];
    logic [63:0] o_res    [2];
    logic        o_zero   [2];
    logic        o_neg    [2];
    logic        o_par    [2];

    int tests = 0;
    int fails = 0;

    logic_result_stage_if #(.w(8))  b8 ();
    logic_result_stage_if #(.w(64)) b64 ();

    logic_result_stage #(.w(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
    logic_result_stage #(.w(64)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

    assign b8.in_valid  = iv[0];
    assign b8.op        = opv[0];
    assign b8.in_0      = av[0][7:0];
    assign b8.in_1      = bv[0][7:0];
    assign b8.out_ready = orv[0];
    assign b64.in_valid  = iv[1];
    assign b64.op        = opv[1];
    assign b64.in_0      = av[1];
    assign b64.in_1      = bv[1];
    assign b64.out_ready = orv[1];

    assign o_iready[0] = b8.in_ready;
    assign o_valid[0]  = b8.out_valid;
    assign o_res[0]    = 64'(b8.result);
    assign o_zero[0]   = b8.zero;
    assign o_neg[0]    = b8.neg;
    assign o_par[0]    = b8.parity;
    assign o_iready[1] = b64.in_ready;
    assign o_valid[1]  = b64.out_valid;
    assign o_res[1]    = b64.result;
    assign o_zero[1]   = b64.zero;
    assign o_neg[1]    = b64.neg;
    assign o_par[1]    = b64.parity;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        chk(name, 64'(act), 64'(exp));
    endtask

    // Reference result of one operation, truncated to the instance width
    function automatic logic [63:0] calc(input logic [1:0] op, input logic [63:0] a,
                                         input logic [63:0] b, input int k);
        logic [63:0] r;
        case (op)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = a ^ b;
            default: r = ~a;
        endcase
        return (k == 0) ? (r & 64'hFF) : r;
    endfunction

    function automatic logic msb(input logic [63:0] v, input int k);
        return (k == 0) ? v[7] : v[63];
    endfunction

    // Model: FIFO queues of expected results and the last popped entry
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    logic [63:0] last_v [2];
    logic        last_z [2];
    logic        last_n [2];
    logic        last_p [2];
    int          m_s0, m_s1;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q0.delete();
                q1.delete();
                for (int k = 0; k < 2; k++) begin
                    last_v[k] = '0; last_z[k] = 1'b0; last_n[k] = 1'b0; last_p[k] = 1'b0;
                end
            end else begin
                m_s0 = q0.size();
                m_s1 = q1.size();
                if (m_s0 > 0 && orv[0]) begin
                    last_v[0] = q0.pop_front();
                    last_z[0] = (last_v[0] == 64'd0);
                    last_n[0] = msb(last_v[0], 0);
                    last_p[0] = ^last_v[0];
                end
                if (iv[0] && m_s0 < 2) q0.push_back(calc(opv[0], av[0], bv[0], 0));
                if (m_s1 > 0 && orv[1]) begin
                    last_v[1] = q1.pop_front();
                    last_z[1] = (last_v[1] == 64'd0);
                    last_n[1] = msb(last_v[1], 1);
                    last_p[1] = ^last_v[1];
                end
                if (iv[1] && m_s1 < 2) q1.push_back(calc(opv[1], av[1], bv[1], 1));
            end
        end
    end

    task automatic cmp(input int k, input int sz, input logic [63:0] head);
        logic [63:0] er;
        logic        ez, en, ep;
        if (sz > 0) begin
            er = head; ez = (head == 64'd0); en = msb(head, k); ep = ^head;
        end else begin
            er = last_v[k]; ez = last_z[k]; en = last_n[k]; ep = last_p[k];
        end
        chkb($sformatf("cmp%0d in_ready", k),  o_iready[k], sz < 2);
        chkb($sformatf("cmp%0d out_valid", k), o_valid[k],  sz != 0);
        chk ($sformatf("cmp%0d result", k),    o_res[k],    er);
        chkb($sformatf("cmp%0d zero", k),      o_zero[k],   ez);
        chkb($sformatf("cmp%0d neg", k),       o_neg[k],    en);
        chkb($sformatf("cmp%0d parity", k),    o_par[k],    ep);
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (q0.size() > 0) cmp(0, q0.size(), q0[0]);
            else               cmp(0, 0, 64'd0);
            if (q1.size() > 0) cmp(1, q1.size(), q1[0]);
            else               cmp(1, 0, 64'd0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one operation until accepted; returns 1 time unit after the push edge
    task automatic send(input int k, input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] b);
        logic rdy;
        int   n;
        opv[k] = op; av[k] = a; bv[k] = b; iv[k] = 1'b1;
        rdy = 1'b0;
        n = 0;
        while (!rdy && n < 20) begin
            @(negedge clk);
            rdy = o_iready[k];
            @(posedge clk);
            #1;
            n++;
        end
        iv[k] = 1'b0;
        chkb($sformatf("send%0d accepted", k), rdy, 1'b1);
    endtask

    task automatic chk_out(input string name, input int k, input logic v, input logic [63:0] r,
                           input logic z, input logic ng, input logic p);
        chkb({name, " out_valid"}, o_valid[k], v);
        chk ({name, " result"},    o_res[k],   r);
        chkb({name, " zero"},      o_zero[k],  z);
        chkb({name, " neg"},       o_neg[k],   ng);
        chkb({name, " parity"},    o_par[k],   p);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int cnt_valid, cnt_drop;

    initial begin
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; opv[k] = 2'b00; av[k] = '0; bv[k] = '0; orv[k] = 1'b0;
        end
        rst_n = 1'b0;
        #12;
        chkb("reset in_ready8", o_iready[0], 1'b0);
        chkb("reset in_ready64", o_iready[1], 1'b0);
        chk_out("reset8", 0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        chk_out("reset64", 1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chkb("release in_ready8", o_iready[0], 1'b1);
        chkb("release in_ready64", o_iready[1], 1'b1);
        tick(1);

        // Per-op values, w=8
        send(0, 2'b10, 64'hA5, 64'h5A);
        chk_out("xor8", 0, 1'b1, 64'hFF, 1'b0, 1'b1, 1'b0);
        orv[0] = 1'b1;
        tick(1);
        chk_out("xor8 held", 0, 1'b0, 64'hFF, 1'b0, 1'b1, 1'b0);
        send(0, 2'b00, 64'hF0, 64'h0F);
        chk_out("and8", 0, 1'b1, 64'h00, 1'b1, 1'b0, 1'b0);
        send(0, 2'b11, 64'h7F, 64'hFF);
        chk_out("not8", 0, 1'b1, 64'h80, 1'b0, 1'b1, 1'b1);
        tick(1);
        orv[0] = 1'b0;

        // Streaming XOR, w=64
        orv[1] = 1'b1;
        cnt_valid = 0;
        cnt_drop = 0;
        fork
            for (int i = 0; i < 10; i++)
                send(1, 2'b10, {$urandom, $urandom}, {$urandom, $urandom});
            repeat (13) begin
                @(negedge clk);
                if (o_valid[1]) cnt_valid++;
                if (!o_iready[1]) cnt_drop++;
            end
        join
        chk("stream valid cycles", 64'(cnt_valid), 64'd10);
        chk("stream in_ready drops", 64'(cnt_drop), 64'd0);
        @(posedge clk);
        #1;
        orv[1] = 1'b0;

        // Back-pressure, w=8
        send(0, 2'b01, 64'h01, 64'h02);
        send(0, 2'b01, 64'h04, 64'h08);
        fork
            send(0, 2'b10, 64'h11, 64'h22);
            begin
                @(negedge clk);
                chkb("bp in_ready low", o_iready[0], 1'b0);
                @(negedge clk);
                chk("bp first", o_res[0], 64'h03);
                orv[0] = 1'b1;
                @(negedge clk);
                chk("bp second", o_res[0], 64'h0C);
                @(negedge clk);
                chk("bp third", o_res[0], 64'h33);
            end
        join
        @(posedge clk);
        #1;
        tick(1);
        orv[0] = 1'b0;

        // Simultaneous push and pop in ONE, w=8
        send(0, 2'b00, 64'hFF, 64'h3C);
        chk_out("sim head", 0, 1'b1, 64'h3C, 1'b0, 1'b0, 1'b0);
        orv[0] = 1'b1;
        send(0, 2'b01, 64'h40, 64'h01);
        chkb("sim in_ready", o_iready[0], 1'b1);
        chk_out("sim advance", 0, 1'b1, 64'h41, 1'b0, 1'b0, 1'b0);
        tick(1);
        chk_out("sim drained", 0, 1'b0, 64'h41, 1'b0, 1'b0, 1'b0);
        orv[0] = 1'b0;

        // Reset with a full buffer
        send(1, 2'b10, 64'h1234, 64'h0);
        send(1, 2'b00, 64'hFFFF_0000_FFFF_0000, 64'hF0F0_F0F0_F0F0_F0F0);
        send(0, 2'b01, 64'h10, 64'h01);
        chkb("pre-reset full", o_iready[1], 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chkb("midreset in_ready64", o_iready[1], 1'b0);
        chkb("midreset in_ready8", o_iready[0], 1'b0);
        chk_out("midreset64", 1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        chk_out("midreset8", 0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chkb("rerelease in_ready64", o_iready[1], 1'b1);
        tick(1);

        // Boundary values, w=64
        orv[1] = 1'b1;
        send(1, 2'b10, 64'h8000_0000_0000_0000, 64'h0);
        chk_out("msb64", 1, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1);
        send(1, 2'b10, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567);
        chk_out("equal64", 1, 1'b1, 64'h0, 1'b1, 1'b0, 1'b0);
        tick(2);
        orv[1] = 1'b0;
        tick(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
